ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, a 4-cycle byte-serial
// multiplier FSM, and the EX/MEM pipeline register.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_MemtoReg,
    input  logic        i_MemWrite,
    input  logic        i_RegWrite,
    input  logic        i_ALUSrc,
    input  logic        i_RegDst,
    input  logic [2:0]  i_ALUControl,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_RD1,
    input  logic [31:0] i_RD2,
    input  logic [31:0] i_signimm,
    input  logic [1:0]  i_ForwardA,
    input  logic [1:0]  i_ForwardB,
    input  logic [31:0] i_ALUOutM,
    input  logic [31:0] i_ResultW,
    input  logic        i_clr,
    output logic        o_MemtoReg,
    output logic        o_MemWrite,
    output logic        o_RegWrite,
    output logic [31:0] o_ALUOut,
    output logic [31:0] o_WriteData,
    output logic [4:0]  o_WriteReg,
    output logic [4:0]  o_WriteRegE,
    output logic        o_stall
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        memto_reg_q, memto_reg_d;
    logic        mem_write_q, mem_write_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] write_data_q, write_data_d;
    logic [4:0]  write_reg_q, write_reg_d;

    logic [31:0] src_a, fwd_b, src_b, alu_result, partial;
    logic [7:0]  mul_byte;
    logic        is_mul;

    // Only the rt/rd fields of the instruction matter in this stage.
    logic unused_inst;
    assign unused_inst = ^{i_inst[31:21], i_inst[10:0]};

    assign is_mul      = (i_ALUControl == ALU_MUL);
    assign o_WriteRegE = i_RegDst ? i_inst[15:11] : i_inst[20:16];
    assign src_b       = i_ALUSrc ? i_signimm : fwd_b;

    always_comb begin
        case (i_ForwardA)
            2'b10:   src_a = i_ALUOutM;
            2'b01:   src_a = i_ResultW;
            default: src_a = i_RD1;
        endcase
        case (i_ForwardB)
            2'b10:   fwd_b = i_ALUOutM;
            2'b01:   fwd_b = i_ResultW;
            default: fwd_b = i_RD2;
        endcase
    end

    always_comb begin
        case (i_ALUControl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'h1 : 32'h0;
            default: alu_result = 32'h0;
        endcase
    end

    // One multiplier byte per BUSY cycle; truncation to 32 bits gives the wrap.
    assign mul_byte = 8'(b_q >> {cnt_q, 3'b000});
    assign partial  = (a_q * {24'h0, mul_byte}) << {cnt_q, 3'b000};

    // NOTE: every variable gets a default at the top of the always_comb,
    // so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        o_stall = 1'b0;
        case (state_q)
            S_IDLE: if (is_mul) begin
                o_stall = 1'b1;
                a_d     = src_a;
                b_d     = src_b;
                acc_d   = 32'h0;
                cnt_d   = 2'd0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                o_stall = 1'b1;
                acc_d   = acc_q + partial;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_clr) state_d = S_IDLE;
    end

    always_comb begin
        memto_reg_d  = i_MemtoReg;
        mem_write_d  = i_MemWrite;
        reg_write_d  = i_RegWrite;
        alu_out_d    = (state_q == S_DONE) ? acc_q : alu_result;
        write_data_d = fwd_b;
        write_reg_d  = o_WriteRegE;
        if (o_stall || i_clr) begin
            memto_reg_d  = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            alu_out_d    = 32'h0;
            write_data_d = 32'h0;
            write_reg_d  = 5'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            acc_q        <= 32'h0;
            cnt_q        <= 2'd0;
            memto_reg_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_out_q    <= 32'h0;
            write_data_q <= 32'h0;
            write_reg_q  <= 5'h0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            memto_reg_q  <= memto_reg_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            alu_out_q    <= alu_out_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign o_MemtoReg  = memto_reg_q;
    assign o_MemWrite  = mem_write_q;
    assign o_RegWrite  = reg_write_q;
    assign o_ALUOut    = alu_out_q;
    assign o_WriteData = write_data_q;
    assign o_WriteReg  = write_reg_q;

endmodule
